// File: rtl/unidad_memoria_if.sv
// Data-memory bus of unidad_memoria: valid/ready request, lane mask,
// write data and full-width read data.
// Ports (master = load/store unit, slave = data memory):
//   mem_valido, mem_hab_escritura, mem_dir, mem_mascara,
//   mem_dat_escritura  -> master drives
//   mem_listo, mem_dat_lectura -> slave drives
interface unidad_memoria_if #(
    parameter int ANCHO     = 32,
    parameter int ANCHO_DIR = 32
);
    logic                 mem_valido;
    logic                 mem_listo;
    logic                 mem_hab_escritura;
    logic [ANCHO_DIR-1:0] mem_dir;
    logic [ANCHO/8-1:0]   mem_mascara;
    logic [ANCHO-1:0]     mem_dat_escritura;
    logic [ANCHO-1:0]     mem_dat_lectura;

    modport master (
        output mem_valido,
        output mem_hab_escritura,
        output mem_dir,
        output mem_mascara,
        output mem_dat_escritura,
        input  mem_listo,
        input  mem_dat_lectura
    );

    modport slave (
        input  mem_valido,
        input  mem_hab_escritura,
        input  mem_dir,
        input  mem_mascara,
        input  mem_dat_escritura,
        output mem_listo,
        output mem_dat_lectura
    );
endinterface

// File: rtl/unidad_memoria.sv
// Load/store unit between the multicycle RV32I control FSM and data memory:
// byte/half/word(/double) accesses, valid/ready handshake with wait states,
// misalignment/illegal-funct3 and timeout detection.
// Ports: clk, reset (async, active low); CPU side inicio, escritura,
//   funct3, dir_cpu, dato_cpu -> ocupado, listo, dato_carga,
//   error_alineacion, error_tiempo; memory side via mem (master modport).
module unidad_memoria #(
    parameter int ANCHO      = 32,
    parameter int ANCHO_DIR  = 32,
    parameter int MAX_ESPERA = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inicio,
    input  logic                 escritura,
    input  logic [2:0]           funct3,
    input  logic [ANCHO_DIR-1:0] dir_cpu,
    input  logic [ANCHO-1:0]     dato_cpu,
    output logic                 ocupado,
    output logic                 listo,
    output logic [ANCHO-1:0]     dato_carga,
    output logic                 error_alineacion,
    output logic                 error_tiempo,
    unidad_memoria_if.master     mem
);
    localparam int NB   = ANCHO / 8;
    localparam int OFFW = $clog2(NB);

    typedef enum logic [1:0] {
        REPOSO,
        PETICION,
        FIN
    } estado_t;

    estado_t estado, estado_sig;

    logic                 es_escritura, es_escritura_sig;
    logic                 sin_signo, sin_signo_sig;
    logic [1:0]           tam, tam_sig;
    logic [OFFW-1:0]      off, off_sig;
    logic [7:0]           cuenta, cuenta_sig;

    logic                 ocupado_sig, listo_sig;
    logic                 err_alin_sig, err_tiempo_sig;
    logic [ANCHO-1:0]     dato_carga_sig;

    logic                 valido, valido_sig;
    logic                 hab, hab_sig;
    logic [ANCHO_DIR-1:0] dir, dir_sig;
    logic [NB-1:0]        mascara, mascara_sig;
    logic [ANCHO-1:0]     dat_esc, dat_esc_sig;

    logic [OFFW-1:0]      off_in;
    logic [3:0]           alin;
    logic                 ilegal;
    logic [NB-1:0]        mascara_in;
    logic [ANCHO-1:0]     dat_in;
    logic [ANCHO-1:0]     desplazado;
    logic [ANCHO-1:0]     extraido;

    assign off_in = dir_cpu[OFFW-1:0];

    // alin holds (size in bytes - 1): low offset bits that must be zero.
    always_comb begin
        unique case (funct3[1:0])
            2'd0: begin
                alin       = 4'd0;
                mascara_in = NB'(1);
            end
            2'd1: begin
                alin       = 4'd1;
                mascara_in = NB'(3);
            end
            2'd2: begin
                alin       = 4'd3;
                mascara_in = NB'(15);
            end
            default: begin
                alin       = 4'd7;
                mascara_in = '1;
            end
        endcase
    end

    always_comb begin
        ilegal = 1'b0;
        if (funct3 == 3'b111)
            ilegal = 1'b1;
        if (ANCHO == 32 && (funct3 == 3'b011 || funct3 == 3'b110))
            ilegal = 1'b1;
        if (escritura && funct3 == 3'b011)
            ilegal = 1'b1;
        if ((4'(off_in) & alin) != 4'd0)
            ilegal = 1'b1;
    end

    // Replicate the low byte/half/word of rs2 across every lane so the
    // mask alone selects where it lands.
    always_comb begin
        dat_in = '0;
        for (int i = 0; i < NB; i++) begin
            unique case (funct3[1:0])
                2'd0:    dat_in[8*i +: 8] = dato_cpu[7:0];
                2'd1:    dat_in[8*i +: 8] = dato_cpu[8*(i%2) +: 8];
                2'd2:    dat_in[8*i +: 8] = dato_cpu[8*(i%4) +: 8];
                default: dat_in[8*i +: 8] = dato_cpu[8*(i%8) +: 8];
            endcase
        end
    end

    assign desplazado = mem.mem_dat_lectura >> {off, 3'b000};

    always_comb begin
        unique case (tam)
            2'd0: extraido = sin_signo ?
                ANCHO'(desplazado[7:0]) :
                ANCHO'($signed(desplazado[7:0]));
            2'd1: extraido = sin_signo ?
                ANCHO'(desplazado[15:0]) :
                ANCHO'($signed(desplazado[15:0]));
            2'd2: extraido = sin_signo ?
                ANCHO'(desplazado[31:0]) :
                ANCHO'($signed(desplazado[31:0]));
            default: extraido = desplazado;
        endcase
    end

    always_comb begin
        estado_sig       = estado;
        es_escritura_sig = es_escritura;
        sin_signo_sig    = sin_signo;
        tam_sig          = tam;
        off_sig          = off;
        cuenta_sig       = cuenta;
        ocupado_sig      = ocupado;
        listo_sig        = listo;
        err_alin_sig     = error_alineacion;
        err_tiempo_sig   = error_tiempo;
        dato_carga_sig   = dato_carga;
        valido_sig       = valido;
        hab_sig          = hab;
        dir_sig          = dir;
        mascara_sig      = mascara;
        dat_esc_sig      = dat_esc;

        unique case (estado)
            REPOSO: begin
                if (inicio) begin
                    es_escritura_sig = escritura;
                    sin_signo_sig    = funct3[2];
                    tam_sig          = funct3[1:0];
                    off_sig          = off_in;
                    ocupado_sig      = 1'b1;
                    if (ilegal) begin
                        estado_sig     = FIN;
                        listo_sig      = 1'b1;
                        err_alin_sig   = 1'b1;
                        dato_carga_sig = '0;
                    end else begin
                        estado_sig  = PETICION;
                        valido_sig  = 1'b1;
                        hab_sig     = escritura;
                        dir_sig     = {dir_cpu[ANCHO_DIR-1:OFFW], OFFW'(0)};
                        mascara_sig = mascara_in << off_in;
                        dat_esc_sig = dat_in;
                        cuenta_sig  = '0;
                    end
                end
            end
            PETICION: begin
                // Ack wins over timeout in the same cycle.
                if (mem.mem_listo) begin
                    estado_sig = FIN;
                    valido_sig = 1'b0;
                    hab_sig    = 1'b0;
                    listo_sig  = 1'b1;
                    if (!es_escritura)
                        dato_carga_sig = extraido;
                end else if (cuenta == 8'(MAX_ESPERA)) begin
                    estado_sig     = FIN;
                    valido_sig     = 1'b0;
                    hab_sig        = 1'b0;
                    listo_sig      = 1'b1;
                    err_tiempo_sig = 1'b1;
                    dato_carga_sig = '0;
                end else begin
                    cuenta_sig = cuenta + 8'd1;
                end
            end
            FIN: begin
                estado_sig     = REPOSO;
                listo_sig      = 1'b0;
                err_alin_sig   = 1'b0;
                err_tiempo_sig = 1'b0;
                ocupado_sig    = 1'b0;
            end
            default: begin
                estado_sig = REPOSO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado           <= REPOSO;
            es_escritura     <= 1'b0;
            sin_signo        <= 1'b0;
            tam              <= 2'd0;
            off              <= '0;
            cuenta           <= 8'd0;
            ocupado          <= 1'b0;
            listo            <= 1'b0;
            error_alineacion <= 1'b0;
            error_tiempo     <= 1'b0;
            dato_carga       <= '0;
            valido           <= 1'b0;
            hab              <= 1'b0;
            dir              <= '0;
            mascara          <= '0;
            dat_esc          <= '0;
        end else begin
            estado           <= estado_sig;
            es_escritura     <= es_escritura_sig;
            sin_signo        <= sin_signo_sig;
            tam              <= tam_sig;
            off              <= off_sig;
            cuenta           <= cuenta_sig;
            ocupado          <= ocupado_sig;
            listo            <= listo_sig;
            error_alineacion <= err_alin_sig;
            error_tiempo     <= err_tiempo_sig;
            dato_carga       <= dato_carga_sig;
            valido           <= valido_sig;
            hab              <= hab_sig;
            dir              <= dir_sig;
            mascara          <= mascara_sig;
            dat_esc          <= dat_esc_sig;
        end
    end

    assign mem.mem_valido        = valido;
    assign mem.mem_hab_escritura = hab;
    assign mem.mem_dir           = dir;
    assign mem.mem_mascara       = mascara;
    assign mem.mem_dat_escritura = dat_esc;
endmodule

// File: tb/tb_unidad_memoria.sv
// Self-checking bench for unidad_memoria (ANCHO=32, MAX_ESPERA=4):
// per-cycle model comparison plus hand-computed literal expectations.
module tb_unidad_memoria;
    localparam int W    = 32;
    localparam int MAXE = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inicio;
    logic        escritura;
    logic [2:0]  funct3;
    logic [31:0] dir_cpu;
    logic [31:0] dato_cpu;
    logic        ocupado;
    logic        listo;
    logic [31:0] dato_carga;
    logic        error_alineacion;
    logic        error_tiempo;

    always #5 clk = ~clk;

    unidad_memoria_if #(.ANCHO(W), .ANCHO_DIR(32)) bus ();

    unidad_memoria #(
        .ANCHO(W),
        .ANCHO_DIR(32),
        .MAX_ESPERA(MAXE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .inicio(inicio),
        .escritura(escritura),
        .funct3(funct3),
        .dir_cpu(dir_cpu),
        .dato_cpu(dato_cpu),
        .ocupado(ocupado),
        .listo(listo),
        .dato_carga(dato_carga),
        .error_alineacion(error_alineacion),
        .error_tiempo(error_tiempo),
        .mem(bus.master)
    );

    int n_ok  = 0;
    int n_tot = 0;

    task automatic chk(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tot++;
        if (act === exp)
            n_ok++;
        else
            $display("FAIL %s: got %0h want %0h at t=%0t",
                     n, act, exp, $time);
    endtask

    // Current transaction as seen by the model
    bit        activo = 1'b0;
    int        ciclo;
    bit        m_esc;
    bit [2:0]  m_f3;
    bit [31:0] m_dir, m_dato, m_rd;
    int        m_waits;
    bit        m_ileg, m_tout;
    int        m_nvalid, m_clisto;
    bit [31:0] m_carga, m_wdat;
    bit [3:0]  m_mask;
    bit [31:0] exp_carga = 32'h0;

    // Values captured from the DUT for the literal checks
    int          cap_listo, cap_nvalid;
    logic [31:0] cap_dir, cap_wdat, cap_carga;
    logic [3:0]  cap_mask;
    logic        cap_hab, cap_ea, cap_et;

    function automatic void modelo();
        int nb, off;
        longint unsigned v, lim;
        nb  = 1 << m_f3[1:0];
        off = int'(m_dir % 4);
        m_ileg = (m_f3 == 3'b111)
              || (W == 32 && (m_f3 == 3'b011 || m_f3 == 3'b110))
              || (m_esc && m_f3 == 3'b011)
              || (off % nb != 0);
        m_tout   = !m_ileg && (m_waits > MAXE);
        m_nvalid = m_ileg ? 0 : (m_waits <= MAXE ? m_waits + 1 : MAXE + 1);
        m_clisto = m_ileg ? 1 : m_nvalid + 1;
        v   = 64'(m_rd) >> (8 * off);
        lim = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
        v   = v & lim;
        if (!m_f3[2] && nb < 8 && ((v >> (8 * nb - 1)) & 64'd1) == 64'd1)
            v = v | ~lim;
        m_carga = v[31:0];
        m_mask  = 4'(((1 << nb) - 1) << off);
        for (int i = 0; i < 4; i++)
            m_wdat[8*i +: 8] = 8'(m_dato >> (8 * (i % nb)));
    endfunction

    bit ev, el, eo;

    always @(negedge clk) begin
        if (activo) begin
            ev = !m_ileg && ciclo >= 1 && ciclo <= m_nvalid;
            el = (ciclo == m_clisto);
            eo = (ciclo >= 1 && ciclo <= m_clisto);
            if (el) begin
                if (m_ileg || m_tout)
                    exp_carga = 32'h0;
                else if (!m_esc)
                    exp_carga = m_carga;
            end
            chk("ocupado", 64'(ocupado), 64'(eo));
            chk("listo", 64'(listo), 64'(el));
            chk("mem_valido", 64'(bus.mem_valido), 64'(ev));
            chk("err_alin", 64'(error_alineacion), 64'(el && m_ileg));
            chk("err_tiempo", 64'(error_tiempo), 64'(el && m_tout));
            chk("dato_carga", 64'(dato_carga), 64'(exp_carga));
            if (ev) begin
                chk("mem_dir", 64'(bus.mem_dir), 64'(m_dir & 32'hFFFF_FFFC));
                chk("mem_mascara", 64'(bus.mem_mascara), 64'(m_mask));
                chk("mem_dat_esc", 64'(bus.mem_dat_escritura), 64'(m_wdat));
                chk("mem_hab_esc", 64'(bus.mem_hab_escritura), 64'(m_esc));
            end
            if (ciclo == 1) begin
                cap_dir  = bus.mem_dir;
                cap_mask = bus.mem_mascara;
                cap_wdat = bus.mem_dat_escritura;
                cap_hab  = bus.mem_hab_escritura;
            end
            if (bus.mem_valido)
                cap_nvalid++;
            if (listo) begin
                cap_listo = ciclo;
                cap_ea    = error_alineacion;
                cap_et    = error_tiempo;
                cap_carga = dato_carga;
            end
        end
    end

    // One access; mem_listo stays low for 'waits' cycles of the request.
    // 'espuria' pulses a second inicio while the unit is busy.
    task automatic acceso(input bit esc, input bit [2:0] f3,
                          input bit [31:0] dir, input bit [31:0] dato,
                          input bit [31:0] rd, input int waits,
                          input bit espuria);
        m_esc   = esc;
        m_f3    = f3;
        m_dir   = dir;
        m_dato  = dato;
        m_rd    = rd;
        m_waits = waits;
        modelo();
        cap_listo  = -1;
        cap_nvalid = 0;
        for (int k = 0; k <= m_clisto; k++) begin
            @(posedge clk);
            #1;
            ciclo  = k;
            activo = 1'b1;
            inicio = (k == 0) || (espuria && k == 1);
            if (k == 0) begin
                escritura = esc;
                funct3    = f3;
                dir_cpu   = dir;
                dato_cpu  = dato;
            end else if (espuria && k == 1) begin
                escritura = 1'b1;
                funct3    = 3'b010;
                dir_cpu   = 32'h300;
                dato_cpu  = 32'h5555_5555;
            end
            bus.mem_listo       = (k > waits);
            bus.mem_dat_lectura = rd;
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset               = 1'b0;
        inicio              = 1'b0;
        escritura           = 1'b0;
        funct3              = 3'b000;
        dir_cpu             = 32'h0;
        dato_cpu            = 32'h0;
        bus.mem_listo       = 1'b0;
        bus.mem_dat_lectura = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ocupado", 64'(ocupado), 64'd0);
        chk("rst_listo", 64'(listo), 64'd0);
        chk("rst_carga", 64'(dato_carga), 64'd0);
        chk("rst_err_alin", 64'(error_alineacion), 64'd0);
        chk("rst_err_tiempo", 64'(error_tiempo), 64'd0);
        chk("rst_valido", 64'(bus.mem_valido), 64'd0);
        chk("rst_hab", 64'(bus.mem_hab_escritura), 64'd0);
        chk("rst_dir", 64'(bus.mem_dir), 64'd0);
        chk("rst_mascara", 64'(bus.mem_mascara), 64'd0);
        chk("rst_dat_esc", 64'(bus.mem_dat_escritura), 64'd0);
        #2 reset = 1'b1;

        // SB at 0x103, zero wait
        acceso(1'b1, 3'b000, 32'h103, 32'hAABB_CCDD, 32'h0, 0, 1'b0);
        chk("sb_dir", 64'(cap_dir), 64'h100);
        chk("sb_mascara", 64'(cap_mask), 64'h8);
        chk("sb_dat", 64'(cap_wdat), 64'hDDDD_DDDD);
        chk("sb_hab", 64'(cap_hab), 64'd1);
        chk("sb_listo_ciclo", 64'(cap_listo), 64'd2);

        // LB / LBU at offset 2
        acceso(1'b0, 3'b000, 32'h102, 32'h0, 32'h12F4_5678, 0, 1'b0);
        chk("lb_carga", 64'(cap_carga), 64'hFFFF_FFF4);
        acceso(1'b0, 3'b100, 32'h102, 32'h0, 32'h12F4_5678, 0, 1'b0);
        chk("lbu_carga", 64'(cap_carga), 64'h0000_00F4);

        // LH at 0x102 with 3 wait cycles
        acceso(1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_1234, 3, 1'b0);
        chk("lh_listo_ciclo", 64'(cap_listo), 64'd5);
        chk("lh_carga", 64'(cap_carga), 64'hFFFF_8001);

        // Misaligned LW, then LD on a 32-bit unit
        acceso(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1'b0);
        chk("lw_mis_listo", 64'(cap_listo), 64'd1);
        chk("lw_mis_err", 64'(cap_ea), 64'd1);
        chk("lw_mis_nvalid", 64'(cap_nvalid), 64'd0);
        chk("lw_mis_carga", 64'(cap_carga), 64'd0);
        acceso(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1'b0);
        chk("ld32_listo", 64'(cap_listo), 64'd1);
        chk("ld32_err", 64'(cap_ea), 64'd1);
        chk("ld32_nvalid", 64'(cap_nvalid), 64'd0);

        // Timeout, then ack arriving exactly at the limit
        acceso(1'b0, 3'b010, 32'h100, 32'h0, 32'h1122_3344, 100, 1'b0);
        chk("to_nvalid", 64'(cap_nvalid), 64'd5);
        chk("to_listo", 64'(cap_listo), 64'd6);
        chk("to_err", 64'(cap_et), 64'd1);
        chk("to_carga", 64'(cap_carga), 64'd0);
        acceso(1'b0, 3'b010, 32'h100, 32'h0, 32'h1122_3344, 4, 1'b0);
        chk("lim_listo", 64'(cap_listo), 64'd6);
        chk("lim_err", 64'(cap_et), 64'd0);
        chk("lim_carga", 64'(cap_carga), 64'h1122_3344);

        // SH with a spurious inicio while busy; store keeps dato_carga
        acceso(1'b1, 3'b001, 32'h102, 32'h1234_ABCD, 32'h0, 1, 1'b1);
        chk("sh_mascara", 64'(cap_mask), 64'hC);
        chk("sh_dat", 64'(cap_wdat), 64'hABCD_ABCD);
        chk("sh_listo", 64'(cap_listo), 64'd3);
        chk("sh_nvalid", 64'(cap_nvalid), 64'd2);
        chk("sh_carga", 64'(cap_carga), 64'h1122_3344);

        // SW, LHU, LB at top lane
        acceso(1'b1, 3'b010, 32'h104, 32'hCAFE_F00D, 32'h0, 0, 1'b0);
        chk("sw_mascara", 64'(cap_mask), 64'hF);
        chk("sw_dir", 64'(cap_dir), 64'h104);
        acceso(1'b0, 3'b101, 32'h100, 32'h0, 32'h1234_F00F, 2, 1'b0);
        chk("lhu_carga", 64'(cap_carga), 64'h0000_F00F);
        chk("lhu_listo", 64'(cap_listo), 64'd4);
        acceso(1'b0, 3'b000, 32'h1FF, 32'h0, 32'h8000_0000, 0, 1'b0);
        chk("lb3_carga", 64'(cap_carga), 64'hFFFF_FF80);
        chk("lb3_dir", 64'(cap_dir), 64'h1FC);

        // Illegal funct3 / misaligned half
        acceso(1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 0, 1'b0);
        chk("lwu32_err", 64'(cap_ea), 64'd1);
        acceso(1'b1, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1'b0);
        chk("sd_err", 64'(cap_ea), 64'd1);
        acceso(1'b0, 3'b111, 32'h100, 32'h0, 32'h0, 0, 1'b0);
        chk("f3_111_err", 64'(cap_ea), 64'd1);
        acceso(1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 1'b0);
        chk("lh_mis_err", 64'(cap_ea), 64'd1);

        // Reset during the second wait cycle
        activo = 1'b0;
        @(posedge clk);
        #1;
        inicio        = 1'b1;
        escritura     = 1'b0;
        funct3        = 3'b010;
        dir_cpu       = 32'h100;
        bus.mem_listo = 1'b0;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_pre_valido", 64'(bus.mem_valido), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_async_valido", 64'(bus.mem_valido), 64'd0);
        chk("rst_async_ocupado", 64'(ocupado), 64'd0);
        bus.mem_listo       = 1'b1;
        bus.mem_dat_lectura = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        chk("rst_ack_listo", 64'(listo), 64'd0);
        chk("rst_ack_valido", 64'(bus.mem_valido), 64'd0);
        chk("rst_ack_carga", 64'(dato_carga), 64'd0);
        #2 reset = 1'b1;
        bus.mem_listo = 1'b0;
        exp_carga     = 32'h0;

        acceso(1'b0, 3'b010, 32'h200, 32'h0, 32'hCAFE_BABE, 1, 1'b0);
        chk("post_rst_dir", 64'(cap_dir), 64'h200);
        chk("post_rst_listo", 64'(cap_listo), 64'd3);
        chk("post_rst_carga", 64'(cap_carga), 64'hCAFE_BABE);

        activo = 1'b0;
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_ok, n_tot);
        $finish;
    end
endmodule

// File: doc/unidad_memoria.md
# unidad_memoria

Parametrised load/store unit placed between the multicycle RV32I control FSM and the data memory. It replaces the word-only, zero-wait memory path. It adds three capabilities: byte, halfword and word accesses (plus doubleword when `ANCHO`=64), a valid/ready handshake with wait states, and misalignment and timeout detection. The CPU issues one access per `inicio` pulse and stalls its FSM until `listo`.

## Interface
- `ANCHO`, 32: data width in bits; legal values 32 and 64.
- `ANCHO_DIR`, 32: address width.
- `MAX_ESPERA`, 15: maximum number of wait cycles before timeout; legal range 1..255.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `inicio`  in  1  one-cycle access request; sampled only in REPOSO.
- `escritura`  in  1  1 = store, 0 = load.
- `funct3`  in  3  RISC-V size/sign field from `inst[14:12]`.
- `dir_cpu`  in  `ANCHO_DIR`  byte address computed by the ALU.
- `dato_cpu`  in  `ANCHO`  store data (rs2), right-aligned.
- `ocupado`  out  1  high from the cycle after `inicio` until `listo`, inclusive.
- `listo`  out  1  one-cycle completion pulse.
- `dato_carga`  out  `ANCHO`  extended load result; valid while `listo`=1, held until the next access.
- `error_alineacion`  out  1  completion flag for a misaligned access or an illegal funct3.
- `error_tiempo`  out  1  completion flag for a memory timeout.
- `mem_valido`  out  1  request valid to memory.
- `mem_listo`  in  1  memory ready/ack.
- `mem_hab_escritura`  out  1  write enable, qualified by `mem_valido`.
- `mem_dir`  out  `ANCHO_DIR`  address aligned down to `ANCHO/8` bytes.
- `mem_mascara`  out  `ANCHO/8`  byte-lane enables.
- `mem_dat_escritura`  out  `ANCHO`  lane-replicated store data.
- `mem_dat_lectura`  in  `ANCHO`  read data, full word.

## Operation
- FSM states are REPOSO, PETICION and FIN. Reset enters REPOSO. All outputs are registered. Reset value of every output is 0.
- **REPOSO**
  - On `inicio`=1, latch `escritura`, `funct3`, `dir_cpu` and `dato_cpu`.
  - Compute the byte offset `off = dir_cpu mod (ANCHO/8)`.
  - Compute the size: 0 = byte, 1 = half, 2 = word, 3 = double.
  - **Illegal or misaligned request:** go to FIN with `error_alineacion`=1. This covers:
    - funct3 ∈ {011, 110} when `ANCHO`=32;
    - funct3 ∈ {111} always;
    - funct3 ∈ {011, 111} on stores;
    - `off` not a multiple of the access size.
    - No memory request is issued in this case.
  - **Legal request:** go to PETICION.
- **PETICION**
  - `mem_valido`=1. `mem_dir`, `mem_mascara`, `mem_hab_escritura` and `mem_dat_escritura` stay stable until acceptance.
  - Mask: contiguous ones of access width starting at lane `off`.
  - Store data: the low byte, half or word of `dato_cpu` is replicated across all lanes.
  - The transfer completes on the edge where `mem_valido` & `mem_listo`:
    - a load captures `mem_dat_lectura`;
    - the FSM goes to FIN.
  - Wait counter:
    - Cleared on entry; increments on each cycle with `mem_listo`=0.
    - If it equals `MAX_ESPERA` while `mem_listo`=0, drop `mem_valido` and go to FIN with `error_tiempo`=1.
- **FIN**
  - `listo`=1 for one cycle, then return to REPOSO.
  - Error flags are valid only in FIN and are cleared on exit.
- **Load extraction**
  - Select the bytes at lane `off`.
  - Sign-extend for LB/LH/LW(64)/LD. Zero-extend for LBU/LHU/LWU.
  - When `ANCHO`=32, LW is the full word with no extension.
  - `dato_carga`=0 on any error.
  - Stores leave `dato_carga` unchanged.
- `inicio` asserted outside REPOSO is ignored. No queueing.
- Reset asserted mid-access forces REPOSO immediately and drops `mem_valido` asynchronously. A memory ack arriving during reset is ignored.

## Timing
- Latency with zero wait (`mem_listo` held 1): `inicio` at cycle 0, `mem_valido` at cycle 1, `listo` at cycle 2.
- With N wait cycles (N < `MAX_ESPERA`): `listo` at cycle 2+N.
- Misaligned or illegal request: `listo` at cycle 1, and `mem_valido` is never asserted.
- Timeout: `mem_valido` is high for exactly `MAX_ESPERA`+1 cycles; `listo` follows in the next cycle.
- If `mem_listo` rises in the same cycle the counter reaches `MAX_ESPERA`, the transfer succeeds. Ack has priority over timeout.
- Back-to-back: a new `inicio` is accepted in the cycle after `listo`, giving a minimum of 3 cycles per access.

## Test plan
- **SB, `ANCHO`=32, zero wait:** `dir_cpu`=0x103, `dato_cpu`=0xAABBCCDD.
  - Cycle 1: `mem_dir`=0x100, `mem_mascara`=4'b1000, `mem_dat_escritura`=0xDDDDDDDD, `mem_hab_escritura`=1.
  - Cycle 2: `listo`=1.
- **LB/LBU at offset 2:** `mem_dat_lectura`=0x12F45678.
  - LB gives `dato_carga`=0xFFFFFFF4.
  - LBU gives 0x000000F4.
- **LH at 0x102 with 3 wait cycles:** `mem_dat_lectura`=0x80011234.
  - `listo` at cycle 5.
  - `dato_carga`=0xFFFF8001.
- **Misaligned LW at 0x101:** `listo`=1 and `error_alineacion`=1 at cycle 1; `mem_valido` stays 0. Repeat with LD when `ANCHO`=32 and expect the same response.
- **Timeout, `MAX_ESPERA`=4, `mem_listo` held 0:** `mem_valido` high for cycles 1–5; `listo`=1 and `error_tiempo`=1 at cycle 6. A second run with `mem_listo`=1 at cycle 5 must complete without error.
- **Reset mid-access:** `reset`=0 during wait cycle 2; `mem_valido`=0 without waiting for a clock edge. After release, the unit is in REPOSO and a fresh LW at 0x200 completes normally. Additionally, an `inicio` pulsed while `ocupado`=1 produces no second access.
